// File: rtl/alarm_ring_ctrl_if.sv
// Alarm ring controller bus: arm/time/button inputs and ring/snooze status.
// slave = ring controller, master = whoever drives times and buttons.
interface alarm_ring_ctrl_if;
  logic        ARM;
  logic [11:0] CUR_TIME;
  logic [11:0] TIME_SET;
  logic [4:0]  BTN;
  logic        RINGING;
  logic        BUZZ;
  logic        SNOOZE_ACTIVE;
  logic [11:0] SNOOZE_LEFT;
  logic [1:0]  SNOOZE_CNT;
  logic        MISSED;

  modport slave (
    input  ARM, CUR_TIME, TIME_SET, BTN,
    output RINGING, BUZZ, SNOOZE_ACTIVE,
    output SNOOZE_LEFT, SNOOZE_CNT, MISSED
  );

  modport master (
    output ARM, CUR_TIME, TIME_SET, BTN,
    input  RINGING, BUZZ, SNOOZE_ACTIVE,
    input  SNOOZE_LEFT, SNOOZE_CNT, MISSED
  );
endinterface

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring controller: time match, buzzer blink, snooze, dismiss, timeout.
// Ports: CLOCK_1ms, RESET (async high), bus (alarm_ring_ctrl_if.slave).
module alarm_ring_ctrl #(
  parameter int TICK_MS        = 1000,
  parameter int RING_TIMEOUT_S = 60,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZE     = 3,
  parameter int BLINK_MS       = 250
) (
  input logic              CLOCK_1ms,
  input logic              RESET,
  alarm_ring_ctrl_if.slave bus
);
  localparam int MSW = (TICK_MS > 1) ? $clog2(TICK_MS) : 1;
  localparam int BKW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
  localparam int RCW_MIN = $clog2(RING_TIMEOUT_S + 1);
  localparam int RCW = (RCW_MIN > 6) ? RCW_MIN : 6;

  localparam logic [MSW-1:0] MS_LAST  = MSW'(TICK_MS - 1);
  localparam logic [BKW-1:0] BK_LAST  = BKW'(BLINK_MS - 1);
  localparam logic [RCW-1:0] RC_LAST  = RCW'(RING_TIMEOUT_S - 1);
  localparam logic [11:0]    SNZ_LOAD = 12'(SNOOZE_S);
  localparam logic [1:0]     SNZ_MAX  = 2'(MAX_SNOOZE);
  localparam logic [11:0]    T_MAX    = 12'd3599;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RING,
    S_SNOOZE,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [1:0]     btn_s1, btn_s2, btn_s3;
  logic           ce, de;
  logic [MSW-1:0] ms_cnt;
  logic [BKW-1:0] blink_cnt;
  logic [RCW-1:0] ring_cnt;
  logic           buzz_q;
  logic [11:0]    snz_left;
  logic [1:0]     snz_cnt;
  logic           missed_q;

  logic sec, same_time, match;
  logic to_ring, to_snz, set_missed, clr_missed;
  logic unused_btn;

  assign unused_btn = ^bus.BTN[3:1];

  assign sec       = (ms_cnt == MS_LAST);
  assign same_time = (bus.CUR_TIME == bus.TIME_SET);
  // An out-of-range alarm time can never be reached by the clock.
  assign match     = same_time && (bus.TIME_SET <= T_MAX);

  always_ff @(posedge CLOCK_1ms or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    to_ring    = 1'b0;
    to_snz     = 1'b0;
    set_missed = 1'b0;
    clr_missed = 1'b0;
    if (!bus.ARM) begin
      state_nx = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          clr_missed = ce;
          if (match) begin
            state_nx = S_RING;
            to_ring  = 1'b1;
          end
        end
        S_RING: begin
          if (ce) begin
            state_nx = S_DONE;
          end else if (de && snz_cnt < SNZ_MAX) begin
            state_nx = S_SNOOZE;
            to_snz   = 1'b1;
          end else if (sec && ring_cnt == RC_LAST) begin
            state_nx   = S_DONE;
            set_missed = 1'b1;
          end
        end
        S_SNOOZE: begin
          if (ce) begin
            state_nx = S_DONE;
          end else if (sec && snz_left == 12'd1) begin
            state_nx = S_RING;
            to_ring  = 1'b1;
          end
        end
        S_DONE: begin
          // Hold off until the matching second has passed.
          if (!same_time) state_nx = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_1ms or posedge RESET) begin
    if (RESET) begin
      btn_s1    <= '0;
      btn_s2    <= '0;
      btn_s3    <= '0;
      ce        <= 1'b0;
      de        <= 1'b0;
      ms_cnt    <= '0;
      blink_cnt <= '0;
      ring_cnt  <= '0;
      buzz_q    <= 1'b0;
      snz_left  <= '0;
      snz_cnt   <= '0;
      missed_q  <= 1'b0;
    end else begin
      btn_s1 <= {bus.BTN[4], bus.BTN[0]};
      btn_s2 <= btn_s1;
      btn_s3 <= btn_s2;
      ce     <= btn_s2[0] & ~btn_s3[0];
      de     <= btn_s2[1] & ~btn_s3[1];

      // Restart on session entry so the first second is a full one.
      if (to_ring || to_snz || sec) ms_cnt <= '0;
      else                          ms_cnt <= ms_cnt + 1'b1;

      if (to_ring)
        ring_cnt <= '0;
      else if (state == S_RING && sec)
        ring_cnt <= ring_cnt + 1'b1;

      if (to_ring) begin
        blink_cnt <= '0;
        buzz_q    <= 1'b1;
      end else if (state == S_RING && state_nx == S_RING) begin
        if (blink_cnt == BK_LAST) begin
          blink_cnt <= '0;
          buzz_q    <= ~buzz_q;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end else begin
        blink_cnt <= '0;
        buzz_q    <= 1'b0;
      end

      if (state_nx != S_SNOOZE)
        snz_left <= '0;
      else if (to_snz)
        snz_left <= SNZ_LOAD;
      else if (sec && snz_left != 12'd0)
        snz_left <= snz_left - 12'd1;

      if (!bus.ARM || (state_nx == S_DONE && state != S_DONE))
        snz_cnt <= '0;
      else if (to_snz)
        snz_cnt <= snz_cnt + 2'd1;

      if (!bus.ARM || clr_missed) missed_q <= 1'b0;
      else if (set_missed)        missed_q <= 1'b1;
    end
  end

  assign bus.RINGING       = (state == S_RING);
  assign bus.SNOOZE_ACTIVE = (state == S_SNOOZE);
  assign bus.BUZZ          = buzz_q;
  assign bus.SNOOZE_LEFT   = snz_left;
  assign bus.SNOOZE_CNT    = snz_cnt;
  assign bus.MISSED        = missed_q;
endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Directed bench for alarm_ring_ctrl with reduced timing parameters.
// Drives inputs and samples outputs 1 time unit after each rising edge.
module tb_alarm_ring_ctrl;
  logic CLOCK_1ms;
  logic RESET;
  int   n_cmp;
  int   n_bad;

  alarm_ring_ctrl_if bus();

  alarm_ring_ctrl #(
    .TICK_MS(10),
    .RING_TIMEOUT_S(5),
    .SNOOZE_S(3),
    .MAX_SNOOZE(2),
    .BLINK_MS(4)
  ) dut (
    .CLOCK_1ms(CLOCK_1ms),
    .RESET(RESET),
    .bus(bus)
  );

  initial CLOCK_1ms = 1'b0;
  always #5 CLOCK_1ms = ~CLOCK_1ms;

  task automatic tick();
    @(posedge CLOCK_1ms);
    #1;
  endtask

  // One-cycle press; the effect shows after one further tick.
  task automatic press(input logic [4:0] b);
    bus.BTN = b;
    tick();
    bus.BTN = '0;
    tick();
    tick();
  endtask

  task automatic trigger();
    bus.CUR_TIME = 12'd124;
    tick();
    tick();
    bus.CUR_TIME = 12'd125;
    tick();
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    bus.ARM = 1'b0;
    bus.BTN = '0;
    bus.CUR_TIME = '0;
    bus.TIME_SET = '0;
    tick();
    tick();
    n_cmp++;
    if ({bus.RINGING, bus.BUZZ, bus.SNOOZE_ACTIVE, bus.MISSED} !== 4'b0) begin
      n_bad++;
      $display("FAIL rst_flags got %b want 0000",
        {bus.RINGING, bus.BUZZ, bus.SNOOZE_ACTIVE, bus.MISSED});
    end
    n_cmp++;
    if ({bus.SNOOZE_LEFT, bus.SNOOZE_CNT} !== 14'd0) begin
      n_bad++;
      $display("FAIL rst_snz got %0d/%0d want 0/0",
        bus.SNOOZE_LEFT, bus.SNOOZE_CNT);
    end
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_no_match();
    bus.ARM = 1'b1;
    bus.TIME_SET = 12'd4000;
    bus.CUR_TIME = 12'd4000;
    repeat (3) tick();
    n_cmp++;
    if (bus.RINGING !== 1'b0) begin
      n_bad++;
      $display("FAIL bad_time got %b want 0", bus.RINGING);
    end
    bus.TIME_SET = 12'd125;
    bus.CUR_TIME = 12'd124;
    tick();
  endtask

  task automatic test_trigger_blink();
    tick();
    bus.CUR_TIME = 12'd125;
    n_cmp++;
    if (bus.RINGING !== 1'b0) begin
      n_bad++;
      $display("FAIL trig_pre got %b want 0", bus.RINGING);
    end
    tick();
    n_cmp++;
    if ({bus.RINGING, bus.BUZZ} !== 2'b11) begin
      n_bad++;
      $display("FAIL trig_ring got %b want 11", {bus.RINGING, bus.BUZZ});
    end
    repeat (3) tick();
    n_cmp++;
    if (bus.BUZZ !== 1'b1) begin
      n_bad++;
      $display("FAIL buzz_c3 got %b want 1", bus.BUZZ);
    end
    tick();
    n_cmp++;
    if (bus.BUZZ !== 1'b0) begin
      n_bad++;
      $display("FAIL buzz_c4 got %b want 0", bus.BUZZ);
    end
    repeat (3) tick();
    n_cmp++;
    if (bus.BUZZ !== 1'b0) begin
      n_bad++;
      $display("FAIL buzz_c7 got %b want 0", bus.BUZZ);
    end
    tick();
    n_cmp++;
    if (bus.BUZZ !== 1'b1) begin
      n_bad++;
      $display("FAIL buzz_c8 got %b want 1", bus.BUZZ);
    end
  endtask

  // Continues the session started by test_trigger_blink (now at +8).
  task automatic test_timeout();
    repeat (41) tick();
    n_cmp++;
    if ({bus.RINGING, bus.MISSED} !== 2'b10) begin
      n_bad++;
      $display("FAIL to_c49 got %b want 10", {bus.RINGING, bus.MISSED});
    end
    tick();
    n_cmp++;
    if ({bus.RINGING, bus.MISSED, bus.BUZZ} !== 3'b010) begin
      n_bad++;
      $display("FAIL to_c50 got %b want 010",
        {bus.RINGING, bus.MISSED, bus.BUZZ});
    end
    repeat (5) tick();
    n_cmp++;
    if (bus.RINGING !== 1'b0) begin
      n_bad++;
      $display("FAIL no_retrig got %b want 0", bus.RINGING);
    end
    bus.CUR_TIME = 12'd126;
    tick();
    n_cmp++;
    if (bus.MISSED !== 1'b1) begin
      n_bad++;
      $display("FAIL missed_hold got %b want 1", bus.MISSED);
    end
    press(5'b00001);
    tick();
    n_cmp++;
    if (bus.MISSED !== 1'b0) begin
      n_bad++;
      $display("FAIL missed_clr got %b want 0", bus.MISSED);
    end
  endtask

  task automatic test_snooze();
    trigger();
    press(5'b10000);
    tick();
    n_cmp++;
    if ({bus.SNOOZE_ACTIVE, bus.RINGING, bus.BUZZ} !== 3'b100) begin
      n_bad++;
      $display("FAIL snz_enter got %b want 100",
        {bus.SNOOZE_ACTIVE, bus.RINGING, bus.BUZZ});
    end
    n_cmp++;
    if ({bus.SNOOZE_LEFT, bus.SNOOZE_CNT} !== {12'd3, 2'd1}) begin
      n_bad++;
      $display("FAIL snz_load got %0d/%0d want 3/1",
        bus.SNOOZE_LEFT, bus.SNOOZE_CNT);
    end
    repeat (9) tick();
    n_cmp++;
    if (bus.SNOOZE_LEFT !== 12'd3) begin
      n_bad++;
      $display("FAIL snz_c9 got %0d want 3", bus.SNOOZE_LEFT);
    end
    tick();
    n_cmp++;
    if (bus.SNOOZE_LEFT !== 12'd2) begin
      n_bad++;
      $display("FAIL snz_c10 got %0d want 2", bus.SNOOZE_LEFT);
    end
    repeat (10) tick();
    n_cmp++;
    if (bus.SNOOZE_LEFT !== 12'd1) begin
      n_bad++;
      $display("FAIL snz_c20 got %0d want 1", bus.SNOOZE_LEFT);
    end
    repeat (9) tick();
    n_cmp++;
    if ({bus.SNOOZE_ACTIVE, bus.RINGING} !== 2'b10) begin
      n_bad++;
      $display("FAIL snz_c29 got %b want 10",
        {bus.SNOOZE_ACTIVE, bus.RINGING});
    end
    tick();
    n_cmp++;
    if ({bus.SNOOZE_ACTIVE, bus.RINGING, bus.BUZZ} !== 3'b011) begin
      n_bad++;
      $display("FAIL snz_c30 got %b want 011",
        {bus.SNOOZE_ACTIVE, bus.RINGING, bus.BUZZ});
    end
    n_cmp++;
    if ({bus.SNOOZE_LEFT, bus.SNOOZE_CNT} !== {12'd0, 2'd1}) begin
      n_bad++;
      $display("FAIL snz_exp got %0d/%0d want 0/1",
        bus.SNOOZE_LEFT, bus.SNOOZE_CNT);
    end
  endtask

  // Continues ringing after the first snooze.
  task automatic test_snooze_limit();
    press(5'b10000);
    tick();
    n_cmp++;
    if ({bus.SNOOZE_ACTIVE, bus.SNOOZE_CNT} !== 3'b110) begin
      n_bad++;
      $display("FAIL lim_snz2 got %b want 110",
        {bus.SNOOZE_ACTIVE, bus.SNOOZE_CNT});
    end
    repeat (30) tick();
    n_cmp++;
    if ({bus.RINGING, bus.SNOOZE_CNT} !== 3'b110) begin
      n_bad++;
      $display("FAIL lim_ring2 got %b want 110",
        {bus.RINGING, bus.SNOOZE_CNT});
    end
    press(5'b10000);
    tick();
    n_cmp++;
    if ({bus.RINGING, bus.SNOOZE_ACTIVE, bus.SNOOZE_CNT} !== 4'b1010) begin
      n_bad++;
      $display("FAIL lim_ignore got %b want 1010",
        {bus.RINGING, bus.SNOOZE_ACTIVE, bus.SNOOZE_CNT});
    end
    press(5'b00001);
    tick();
    n_cmp++;
    if ({bus.RINGING, bus.SNOOZE_CNT, bus.MISSED} !== 4'b0000) begin
      n_bad++;
      $display("FAIL lim_dismiss got %b want 0000",
        {bus.RINGING, bus.SNOOZE_CNT, bus.MISSED});
    end
  endtask

  task automatic test_priority();
    trigger();
    press(5'b10001);
    tick();
    n_cmp++;
    if ({bus.RINGING, bus.SNOOZE_ACTIVE, bus.SNOOZE_CNT} !== 4'b0000) begin
      n_bad++;
      $display("FAIL pri_ce_de got %b want 0000",
        {bus.RINGING, bus.SNOOZE_ACTIVE, bus.SNOOZE_CNT});
    end
    trigger();
    repeat (46) tick();
    press(5'b00001);
    n_cmp++;
    if (bus.RINGING !== 1'b1) begin
      n_bad++;
      $display("FAIL pri_c49 got %b want 1", bus.RINGING);
    end
    tick();
    n_cmp++;
    if ({bus.RINGING, bus.MISSED} !== 2'b00) begin
      n_bad++;
      $display("FAIL pri_ce_to got %b want 00",
        {bus.RINGING, bus.MISSED});
    end
  endtask

  task automatic test_disarm();
    trigger();
    press(5'b10000);
    repeat (6) tick();
    n_cmp++;
    if ({bus.SNOOZE_ACTIVE, bus.SNOOZE_LEFT} !== {1'b1, 12'd3}) begin
      n_bad++;
      $display("FAIL dis_pre got %b/%0d want 1/3",
        bus.SNOOZE_ACTIVE, bus.SNOOZE_LEFT);
    end
    bus.ARM = 1'b0;
    tick();
    n_cmp++;
    if ({bus.SNOOZE_ACTIVE, bus.RINGING, bus.SNOOZE_CNT} !== 4'b0000) begin
      n_bad++;
      $display("FAIL dis_idle got %b want 0000",
        {bus.SNOOZE_ACTIVE, bus.RINGING, bus.SNOOZE_CNT});
    end
    n_cmp++;
    if (bus.SNOOZE_LEFT !== 12'd0) begin
      n_bad++;
      $display("FAIL dis_left got %0d want 0", bus.SNOOZE_LEFT);
    end
    bus.CUR_TIME = 12'd124;
    bus.ARM = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid();
    trigger();
    press(5'b10000);
    repeat (31) tick();
    n_cmp++;
    if ({bus.RINGING, bus.BUZZ, bus.SNOOZE_CNT} !== 4'b1101) begin
      n_bad++;
      $display("FAIL rm_pre got %b want 1101",
        {bus.RINGING, bus.BUZZ, bus.SNOOZE_CNT});
    end
    RESET = 1'b1;
    #2;
    n_cmp++;
    if ({bus.RINGING, bus.BUZZ, bus.SNOOZE_CNT, bus.MISSED} !== 5'b0) begin
      n_bad++;
      $display("FAIL rm_async got %b want 00000",
        {bus.RINGING, bus.BUZZ, bus.SNOOZE_CNT, bus.MISSED});
    end
    tick();
    RESET = 1'b0;
    tick();
    n_cmp++;
    if ({bus.RINGING, bus.BUZZ} !== 2'b11) begin
      n_bad++;
      $display("FAIL rm_retrig got %b want 11", {bus.RINGING, bus.BUZZ});
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_no_match();
    test_trigger_blink();
    test_timeout();
    test_snooze();
    test_snooze_limit();
    test_priority();
    test_disarm();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
